// File: rtl/fifo_ctrl_prog.sv
// FIFO pointer and status controller for an external dual-port storage array.
// Supports any DEPTH >= 2 with explicit pointer wrap and runtime almost-full/empty
// thresholds. It also provides a synchronous flush and overflow/underflow pulses.
// Software is expected to program af_thresh_i = DEPTH - DEPTH/4 and
// ae_thresh_i = DEPTH/4 after reset.
// Optional: define FIFO_CTRL_STICKY_ERR_EN to add err_clr_i, ovf_sticky_o and udf_sticky_o.
module fifo_ctrl_prog #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  flush_i,
    input  logic [CNT_WIDTH-1:0]  af_thresh_i,
    input  logic [CNT_WIDTH-1:0]  ae_thresh_i,
`ifdef FIFO_CTRL_STICKY_ERR_EN
    input  logic                  err_clr_i,
    output logic                  ovf_sticky_o,
    output logic                  udf_sticky_o,
`endif
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  wr_accept_o,
    output logic                  rd_accept_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic [CNT_WIDTH-1:0]  w_count_o
);

    localparam logic [ADDR_WIDTH-1:0] PtrLast = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CntFull = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full, empty;
    logic                  wr_accept, rd_accept;

    // Status and accept gating, all from registered occupancy (no write/read-through).
    always_comb begin
        full      = (count_q == CntFull);
        empty     = (count_q == '0);
        wr_accept = wr_en_i & ~full & ~flush_i;
        rd_accept = rd_en_i & ~empty & ~flush_i;
    end

    // Next-state: flush clears everything and suppresses error pulses.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            ovf_d = wr_en_i & full;
            udf_d = rd_en_i & empty;
            if (wr_accept) begin
                wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (rd_accept) begin
                rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
            end
            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, occupancy and error-pulse registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef FIFO_CTRL_STICKY_ERR_EN
    logic ovf_sticky_q, ovf_sticky_d;
    logic udf_sticky_q, udf_sticky_d;

    // Sticky error bits: set beats clear, flush leaves them alone.
    always_comb begin
        ovf_sticky_d = (ovf_sticky_q & ~err_clr_i) | ovf_d;
        udf_sticky_d = (udf_sticky_q & ~err_clr_i) | udf_d;
    end

    // Sticky error registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ovf_sticky_q <= 1'b0;
            udf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            udf_sticky_q <= udf_sticky_d;
        end
    end

    assign ovf_sticky_o = ovf_sticky_q;
    assign udf_sticky_o = udf_sticky_q;
`endif

    // Output drive.
    always_comb begin
        wr_addr_o      = wr_ptr_q;
        rd_addr_o      = rd_ptr_q;
        wr_accept_o    = wr_accept;
        rd_accept_o    = rd_accept;
        full_o         = full;
        empty_o        = empty;
        almost_full_o  = (count_q >= af_thresh_i);
        almost_empty_o = (count_q <= ae_thresh_i);
        overflow_o     = ovf_q;
        underflow_o    = udf_q;
        w_count_o      = count_q;
    end

endmodule

// File: tb/tb_fifo_ctrl_prog.sv
// Self-checking bench for fifo_ctrl_prog (DEPTH=6): directed scenarios plus randomized
// traffic, every output compared each cycle against a queue-free occupancy model.
module tb_fifo_ctrl_prog;

    localparam int unsigned DEPTH    = 6;
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = $clog2(DEPTH + 1);
    localparam int unsigned AF_RESET = DEPTH - DEPTH / 4;
    localparam int unsigned AE_RESET = DEPTH / 4;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          wr_en, rd_en, flush;
    logic [CW-1:0] af_thresh, ae_thresh;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          wr_accept, rd_accept, full, empty, almost_full, almost_empty;
    logic          overflow, underflow;
    logic [CW-1:0] w_count;
`ifdef FIFO_CTRL_STICKY_ERR_EN
    logic          err_clr;
    logic          ovf_sticky, udf_sticky;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int m_cnt, m_wp, m_rp;
    bit m_ovf, m_udf;
`ifdef FIFO_CTRL_STICKY_ERR_EN
    bit m_ovf_st, m_udf_st;
`endif

    fifo_ctrl_prog #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .arst_ni        (arst_n),
        .wr_en_i        (wr_en),
        .rd_en_i        (rd_en),
        .flush_i        (flush),
        .af_thresh_i    (af_thresh),
        .ae_thresh_i    (ae_thresh),
`ifdef FIFO_CTRL_STICKY_ERR_EN
        .err_clr_i      (err_clr),
        .ovf_sticky_o   (ovf_sticky),
        .udf_sticky_o   (udf_sticky),
`endif
        .wr_addr_o      (wr_addr),
        .rd_addr_o      (rd_addr),
        .wr_accept_o    (wr_accept),
        .rd_accept_o    (rd_accept),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .overflow_o     (overflow),
        .underflow_o    (underflow),
        .w_count_o      (w_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
`ifdef FIFO_CTRL_STICKY_ERR_EN
        m_ovf_st = 0; m_udf_st = 0;
`endif
    endtask

    // Compare every output against the model for the currently applied inputs.
    task automatic check_all();
        bit exp_wa, exp_ra;
        exp_wa = wr_en && m_cnt < DEPTH && !flush;
        exp_ra = rd_en && m_cnt > 0 && !flush;
        check_eq("wr_addr", int'(wr_addr), m_wp);
        check_eq("rd_addr", int'(rd_addr), m_rp);
        check_eq("wr_accept", int'(wr_accept), int'(exp_wa));
        check_eq("rd_accept", int'(rd_accept), int'(exp_ra));
        check_eq("full", int'(full), int'(m_cnt == DEPTH));
        check_eq("empty", int'(empty), int'(m_cnt == 0));
        check_eq("almost_full", int'(almost_full), int'(m_cnt >= int'(af_thresh)));
        check_eq("almost_empty", int'(almost_empty), int'(m_cnt <= int'(ae_thresh)));
        check_eq("overflow", int'(overflow), int'(m_ovf));
        check_eq("underflow", int'(underflow), int'(m_udf));
        check_eq("w_count", int'(w_count), m_cnt);
`ifdef FIFO_CTRL_STICKY_ERR_EN
        check_eq("ovf_sticky", int'(ovf_sticky), int'(m_ovf_st));
        check_eq("udf_sticky", int'(udf_sticky), int'(m_udf_st));
`endif
    endtask

    // Advance the model by one clock edge using the FIFO rules directly.
    task automatic model_step();
        bit wa, ra, ovf_ev, udf_ev;
        ovf_ev = !flush && wr_en && m_cnt == DEPTH;
        udf_ev = !flush && rd_en && m_cnt == 0;
        wa = !flush && wr_en && m_cnt < DEPTH;
        ra = !flush && rd_en && m_cnt > 0;
        if (flush) begin
            m_cnt = 0; m_wp = 0; m_rp = 0;
        end else begin
            m_cnt = m_cnt + int'(wa) - int'(ra);
            if (wa) m_wp = (m_wp + 1) % DEPTH;
            if (ra) m_rp = (m_rp + 1) % DEPTH;
        end
        m_ovf = ovf_ev;
        m_udf = udf_ev;
`ifdef FIFO_CTRL_STICKY_ERR_EN
        m_ovf_st = ovf_ev || (m_ovf_st && !err_clr);
        m_udf_st = udf_ev || (m_udf_st && !err_clr);
`endif
    endtask

    // Apply inputs just after an edge, check mid-cycle, then clock.
    task automatic step(input bit w, input bit r, input bit f);
        wr_en = w; rd_en = r; flush = f;
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b0; wr_en = 0; rd_en = 0; flush = 0;
        af_thresh = CW'(AF_RESET); ae_thresh = CW'(AE_RESET);
`ifdef FIFO_CTRL_STICKY_ERR_EN
        err_clr = 0;
`endif
        model_reset();
        #12;
        check_all();
        check_eq("rst_empty", int'(empty), 1);
        check_eq("rst_almost_empty", int'(almost_empty), 1);
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Fill to full, then one rejected write.
        af_thresh = 3'd4; ae_thresh = 3'd1;
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
        check_eq("full_after_fill", int'(full), 1);
        step(1, 0, 0);
        check_eq("ovf_pulse", int'(overflow), 1);
        check_eq("count_stays_full", int'(w_count), DEPTH);
        step(0, 0, 0);
        check_eq("ovf_one_cycle", int'(overflow), 0);
        af_thresh = 3'd7;
        #1;
        check_eq("af_beyond_depth", int'(almost_full), 0);
        af_thresh = 3'd4;

        // Drain, underflow, then wrap the write pointer.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
        check_eq("empty_after_drain", int'(empty), 1);
        check_eq("rd_wrapped", int'(rd_addr), 0);
        step(0, 1, 0);
        check_eq("udf_pulse", int'(underflow), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        check_eq("wr_addr_after_wrap", int'(wr_addr), 3);

        // Flush at count 3 with a write request.
        step(1, 0, 1);
        check_eq("flush_count", int'(w_count), 0);
        check_eq("flush_no_ovf", int'(overflow), 0);

        // Simultaneous requests on empty and on full.
        step(1, 1, 0);
        check_eq("simul_empty_udf", int'(underflow), 1);
        check_eq("simul_empty_cnt", int'(w_count), 1);
        for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 0);
        step(1, 1, 0);
        check_eq("simul_full_ovf", int'(overflow), 1);
        check_eq("simul_full_cnt", int'(w_count), DEPTH - 1);

`ifdef FIFO_CTRL_STICKY_ERR_EN
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        check_eq("sticky_thru_flush", int'(ovf_sticky), 1);
        err_clr = 1; step(0, 0, 0); err_clr = 0;
        check_eq("sticky_cleared", int'(ovf_sticky), 0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
        err_clr = 1; step(1, 0, 0); err_clr = 0;
        check_eq("sticky_set_wins", int'(ovf_sticky), 1);
`endif

        // Randomized traffic with changing thresholds.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) af_thresh = CW'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) ae_thresh = CW'($urandom_range(0, 7));
`ifdef FIFO_CTRL_STICKY_ERR_EN
            err_clr = ($urandom_range(0, 9) == 0);
`endif
            if (i % 400 < 200)
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 63) == 0));
            else
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 63) == 0));
        end
`ifdef FIFO_CTRL_STICKY_ERR_EN
        err_clr = 0;
`endif

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        wr_en = 1; rd_en = 0; flush = 0;
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_count", int'(w_count), 0);
        check_eq("arst_wr_addr", int'(wr_addr), 0);
        check_eq("arst_empty", int'(empty), 1);
        wr_en = 0;
        #1;
        check_all();
        arst_n = 1'b1;
        @(posedge clk); #1;
        step(1, 1, 0);
        step(0, 0, 0);
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
